if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request/valid
// handshake, buffers a response while the pipeline is stalled, drops responses of
// squashed fetches and loads the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWr,
    input  logic        IFIDWr,
    input  logic        flush,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    output logic [31:0] IFIDInstr,
    output logic [31:0] IFIDPCPlus4,
    output logic        IFIDValid,
    output logic        fetchStall
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] pend_next;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_instr_next;
    logic [XLEN-1:0] hold_pc4;
    logic [XLEN-1:0] hold_pc4_next;
    logic [XLEN-1:0] ifid_instr_next;
    logic [XLEN-1:0] ifid_pc4_next;
    logic            ifid_valid_next;
    logic            bubble;

    logic            advance;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;

    // A PCWr/IFIDWr mismatch counts as a stall; redirect targets are word aligned.
    assign advance  = PCWr & IFIDWr;
    assign pc_plus4 = pc + XLEN'(4);
    assign target   = branchTarget & ~XLEN'(3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (imemValid) begin
                    if (!flush && !advance) begin
                        state_next = S_HOLD;
                    end
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imemValid) begin
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush || advance) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only (fetchStall also sees the strobe).
    always_comb begin
        imemReq    = 1'b0;
        fetchStall = 1'b0;
        unique case (state)
            S_REQ: begin
                imemReq    = 1'b1;
                fetchStall = !imemValid;
            end
            S_DROP: begin
                imemReq    = 1'b1;
                fetchStall = 1'b1;
            end
            default: begin
                imemReq    = 1'b0;
                fetchStall = 1'b0;
            end
        endcase
    end

    // During DROP the pc still holds the squashed address, so the bus stays stable.
    assign imemAddr = pc;

    // Datapath next values: pc, pending redirect, hold buffer and IF/ID slot.
    always_comb begin
        pc_next         = pc;
        pend_next       = pend;
        hold_instr_next = hold_instr;
        hold_pc4_next   = hold_pc4;
        ifid_instr_next = IFIDInstr;
        ifid_pc4_next   = IFIDPCPlus4;
        ifid_valid_next = IFIDValid;
        bubble          = 1'b0;
        unique case (state)
            S_REQ: begin
                if (imemValid) begin
                    if (flush) begin
                        pc_next = target;
                        bubble  = 1'b1;
                    end else if (advance) begin
                        ifid_instr_next = imemRdata;
                        ifid_pc4_next   = pc_plus4;
                        ifid_valid_next = 1'b1;
                        pc_next         = pc_plus4;
                    end else begin
                        hold_instr_next = imemRdata;
                        hold_pc4_next   = pc_plus4;
                    end
                end else if (flush) begin
                    pend_next = target;
                    bubble    = 1'b1;
                end else if (IFIDWr) begin
                    bubble = 1'b1;
                end
            end
            S_DROP: begin
                if (flush) begin
                    pend_next = target;
                end
                if (imemValid) begin
                    pc_next = flush ? target : pend;
                end
                bubble = flush | IFIDWr;
            end
            S_HOLD: begin
                if (flush) begin
                    pc_next = target;
                    bubble  = 1'b1;
                end else if (advance) begin
                    ifid_instr_next = hold_instr;
                    ifid_pc4_next   = hold_pc4;
                    ifid_valid_next = 1'b1;
                    pc_next         = pc_plus4;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
        if (bubble) begin
            ifid_instr_next = NOP_INSTR;
            ifid_valid_next = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            pend        <= RESET_PC;
            hold_instr  <= '0;
            hold_pc4    <= '0;
            IFIDInstr   <= NOP_INSTR;
            IFIDPCPlus4 <= '0;
            IFIDValid   <= 1'b0;
        end else begin
            pc          <= pc_next;
            pend        <= pend_next;
            hold_instr  <= hold_instr_next;
            hold_pc4    <= hold_pc4_next;
            IFIDInstr   <= ifid_instr_next;
            IFIDPCPlus4 <= ifid_pc4_next;
            IFIDValid   <= ifid_valid_next;
        end
    end

endmodule
